cp0_reg: RTL
============

// Module: cp0_reg
// PURPOSE
//  Coprocessor-0 system-control register file. Sits downstream of the MEM/WB pipeline register.
//  Consumes its CP0 write triple (we/addr/data) and the exception summary from the MEM stage.
//  Holds Count/Compare/Status/Cause/EPC/PRId/Config, generates the timer interrupt and supplies
//  current values to the MEM stage (exception decision) and EX stage (mfc0 reads).
// PARAMETERS
//  PRID_VAL    32'h004C0102  reset/constant value of PRId (reg 15), read-only
//  CONFIG_VAL  32'h00008000  reset/constant value of Config (reg 16, BE=1), read-only
//  STATUS_RST  32'h10000000  reset value of Status (CU0=1)
// PORTS
//  clk                  in   1   clock, all state updates on rising edge
//  rst                  in   1   reset, asynchronous, active-low
//  we_i                 in   1   CP0 write enable from MEM/WB
//  waddr_i              in   5   CP0 register number to write
//  data_i               in   32  write data
//  raddr_i              in   5   CP0 register number to read
//  int_i                in   6   external hardware interrupt lines (IP7..IP2)
//  excepttype_i         in   32  exception code from MEM stage (0 = none)
//  current_inst_addr_i  in   32  PC of the instruction in MEM
//  is_in_delayslot_i    in   1   MEM instruction is in a branch delay slot
//  data_o               out  32  read data for raddr_i (combinational)
//  count_o              out  32  Count (reg 9)
//  compare_o            out  32  Compare (reg 11)
//  status_o             out  32  Status (reg 12)
//  cause_o              out  32  Cause (reg 13)
//  epc_o                out  32  EPC (reg 14)
//  config_o             out  32  Config (reg 16)
//  prid_o               out  32  PRId (reg 15)
//  timer_int_o          out  1   timer interrupt request, level, sticky
// BEHAVIOUR
//  Reset (rst=0, any time, async): count/compare/cause/epc=0, status=STATUS_RST,
//   config=CONFIG_VAL, prid=PRID_VAL, timer_int_o=0. Mid-operation reset aborts all pending updates.
//  Every cycle out of reset:
//   - count <= count+1, modulo 2^32 (32'hFFFFFFFF -> 0).
//   - cause[15:10] <= int_i (sampled, 1-cycle latency).
//   - if compare!=0 && count==compare (pre-increment values): timer_int_o <= 1, held until cleared.
//  Software write (we_i=1, excepttype_i==0), written value visible next cycle:
//   - 9  Count: data_i replaces the increment this cycle.
//   - 11 Compare: compare <= data_i; timer_int_o <= 0. A clear beats a same-cycle match.
//   - 12 Status: all 32 bits. 14 EPC: all 32 bits.
//   - 13 Cause: only IP[1:0]=bits 9:8, WP=bit 22, IV=bit 23. Other bits unchanged.
//   - 15/16 and unmapped addresses: write ignored.
//  Exception (excepttype_i!=0) has priority: a software write in the same cycle is dropped.
//   - 32'h1 intr: ExcCode 0. 32'h8 syscall: 8. 32'ha invalid: 10. 32'hd trap: 13. 32'hc ovf: 12.
//   - For the codes above, if status[1] (EXL)==0:
//     epc <= is_in_delayslot_i ? current_inst_addr_i-4 : current_inst_addr_i; cause[31] BD <= is_in_delayslot_i.
//   - If EXL==1: epc and BD are unchanged.
//   - Always: status[1] <= 1 and cause[6:2] <= ExcCode.
//   - 32'he eret: status[1] <= 0; nothing else changes.
//   - Any other nonzero code: no state change.
//  Read: data_o = the register selected by raddr_i (9,11,12,13,14,15,16). Unmapped addresses read 0.
//   There is no write-to-read bypass; EX forwarding handles hazards upstream.
//  Outputs *_o are the registered values (no bypass).
// TESTING
//  Reset: release rst -> status=32'h10000000, config=32'h00008000, prid=32'h004C0102, count=0, timer_int_o=0.
//  Timer: write Compare=5 at count=0. timer_int_o rises the cycle after count==5 and stays 1.
//   Then write Compare=32'h100 -> timer_int_o=0 the next cycle.
//  Syscall in a delay slot: excepttype=8, addr=32'h100, delayslot=1, EXL=0
//   -> epc=32'hFC, cause[31]=1, cause[6:2]=8, status[1]=1.
//  Nested exception: with EXL=1, excepttype=32'hc at addr 32'h200 -> epc stays 32'hFC, ExcCode=12.
//   Then eret (32'he) -> status[1]=0.
//  Cause mask: write Cause=32'hFFFFFFFF -> only bits 23,22,9,8 set (cause=32'h00C00300 with int_i=0).
//   With int_i=6'h3F, cause[15:10] reads all ones the next cycle.
//  Collision and async reset: write Status while excepttype=1 -> write is dropped and EXL=1.
//   Count=32'hFFFFFFFF wraps to 0. Asserting rst mid-count zeros count without waiting for a clock edge.

Source files
------------

// File: rtl/cp0_reg.sv
// CP0 system-control registers (Count/Compare/Status/Cause/EPC/PRId/Config) and timer interrupt.
// Updates land one cycle after the request; data_o is a combinational read. No backpressure: every cycle is accepted.
module cp0_reg #(
   parameter logic [31:0] PRID_VAL   = 32'h004C0102,
   parameter logic [31:0] CONFIG_VAL = 32'h00008000,
   parameter logic [31:0] STATUS_RST = 32'h10000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] data_i,
   input  logic [4:0]  raddr_i,
   input  logic [5:0]  int_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic        is_in_delayslot_i,
   output logic [31:0] data_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] config_o,
   output logic [31:0] prid_o,
   output logic        timer_int_o
);

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;
   localparam logic [4:0] REG_CONFIG  = 5'd16;

   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic [31:0] r_status;
   logic [31:0] r_cause;
   logic [31:0] r_epc;
   logic        r_timer_int;

   logic        w_sw_we;
   logic        w_exc_take;
   logic        w_eret;
   logic [4:0]  w_exc_code;
   logic        w_exl;

   assign w_sw_we = we_i && (excepttype_i == 32'd0);
   assign w_exl   = r_status[1];

   always_comb begin
      w_exc_take = 1'b0;
      w_eret     = 1'b0;
      w_exc_code = 5'd0;
      case (excepttype_i)
         32'h0000_0001: begin w_exc_take = 1'b1; w_exc_code = 5'd0;  end
         32'h0000_0008: begin w_exc_take = 1'b1; w_exc_code = 5'd8;  end
         32'h0000_000a: begin w_exc_take = 1'b1; w_exc_code = 5'd10; end
         32'h0000_000d: begin w_exc_take = 1'b1; w_exc_code = 5'd13; end
         32'h0000_000c: begin w_exc_take = 1'b1; w_exc_code = 5'd12; end
         32'h0000_000e: w_eret = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count     <= 32'd0;
         r_compare   <= 32'd0;
         r_timer_int <= 1'b0;
      end else begin
         if (w_sw_we && waddr_i == REG_COUNT)
            r_count <= data_i;
         else
            r_count <= r_count + 32'd1;
         if (w_sw_we && waddr_i == REG_COMPARE)
            r_compare <= data_i;
         // Rewriting Compare acknowledges the timer even if it matches this very cycle.
         if (w_sw_we && waddr_i == REG_COMPARE)
            r_timer_int <= 1'b0;
         else if (r_compare != 32'd0 && r_count == r_compare)
            r_timer_int <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_status <= STATUS_RST;
         r_epc    <= 32'd0;
      end else if (w_exc_take) begin
         r_status[1] <= 1'b1;
         if (!w_exl)
            r_epc <= is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;
      end else if (w_eret) begin
         r_status[1] <= 1'b0;
      end else if (w_sw_we) begin
         if (waddr_i == REG_STATUS)
            r_status <= data_i;
         if (waddr_i == REG_EPC)
            r_epc <= data_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cause <= 32'd0;
      end else begin
         r_cause[15:10] <= int_i;
         if (w_exc_take) begin
            r_cause[6:2] <= w_exc_code;
            if (!w_exl)
               r_cause[31] <= is_in_delayslot_i;
         end else if (w_sw_we && waddr_i == REG_CAUSE) begin
            r_cause[9:8] <= data_i[9:8];
            r_cause[22]  <= data_i[22];
            r_cause[23]  <= data_i[23];
         end
      end
   end

   always_comb begin
      data_o = 32'd0;
      case (raddr_i)
         REG_COUNT:   data_o = r_count;
         REG_COMPARE: data_o = r_compare;
         REG_STATUS:  data_o = r_status;
         REG_CAUSE:   data_o = r_cause;
         REG_EPC:     data_o = r_epc;
         REG_PRID:    data_o = PRID_VAL;
         REG_CONFIG:  data_o = CONFIG_VAL;
         default:     data_o = 32'd0;
      endcase
   end

   assign count_o     = r_count;
   assign compare_o   = r_compare;
   assign status_o    = r_status;
   assign cause_o     = r_cause;
   assign epc_o       = r_epc;
   assign config_o    = CONFIG_VAL;
   assign prid_o      = PRID_VAL;
   assign timer_int_o = r_timer_int;

endmodule
